// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared encodings for the MIPS MEM stage
package mips_mem_pkg;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b11;

    localparam logic [3:0] BE_ALL     = 4'b1111;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

    // Width 2'b10 is reserved and treated as a word access.
    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] lo);
        logic bad;
        case (width)
            W_BYTE:  bad = 1'b0;
            W_HALF:  bad = lo[0];
            default: bad = (lo != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - store byte-lane steering and load extraction/extension
module mem_lane_align
    import mips_mem_pkg::*;
#(
    parameter int NB_DATA = 32
) (
    input  logic               i_st_write,
    input  logic [1:0]         i_st_width,
    input  logic [1:0]         i_st_lo,
    input  logic [NB_DATA-1:0] i_st_data,
    input  logic [1:0]         i_ld_width,
    input  logic [1:0]         i_ld_lo,
    input  logic               i_ld_sign,
    input  logic [NB_DATA-1:0] i_ld_rdata,
    output logic [3:0]         o_be,
    output logic [NB_DATA-1:0] o_wdata,
    output logic [NB_DATA-1:0] o_rdata_ext
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        o_be    = BE_ALL;
        o_wdata = i_st_data;
        if (i_st_write) begin
            case (i_st_width)
                W_BYTE: begin
                    o_be    = BE_BYTE0 << i_st_lo;
                    o_wdata = {(NB_DATA/8){i_st_data[7:0]}};
                end
                W_HALF: begin
                    o_be    = i_st_lo[1] ? BE_HI_HALF : BE_LO_HALF;
                    o_wdata = {(NB_DATA/16){i_st_data[15:0]}};
                end
                default: begin
                    o_be    = BE_ALL;
                    o_wdata = i_st_data;
                end
            endcase
        end
    end

    // Little-endian lanes: byte n lives in bits [8n+7:8n].
    always_comb begin
        ld_byte = i_ld_rdata[{i_ld_lo, 3'b000} +: 8];
        ld_half = i_ld_lo[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
        case (i_ld_width)
            W_BYTE:  o_rdata_ext = {{(NB_DATA-8){i_ld_sign & ld_byte[7]}}, ld_byte};
            W_HALF:  o_rdata_ext = {{(NB_DATA-16){i_ld_sign & ld_half[15]}}, ld_half};
            default: o_rdata_ext = i_ld_rdata;
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// rtl/memory_access_stage.sv - MIPS MEM stage: req/ack data-memory access and MEM/WB register
// Optional alignment trap enabled by defining MEM_ALIGN_CHECK_EN.
module memory_access_stage
    import mips_mem_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 32
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_halt,
    input  logic               i_mem2reg,
    input  logic               i_memRead,
    input  logic               i_memWrite,
    input  logic               i_regWrite,
    input  logic [1:0]         i_width,
    input  logic               i_sign_flag,
    input  logic [4:0]         i_write_reg,
    input  logic [NB_DATA-1:0] i_result,
    input  logic [NB_DATA-1:0] i_data4Mem,
    output logic               o_dm_req,
    output logic               o_dm_we,
    output logic [NB_ADDR-1:0] o_dm_addr,
    output logic [3:0]         o_dm_be,
    output logic [NB_DATA-1:0] o_dm_wdata,
    input  logic               i_dm_ack,
    input  logic [NB_DATA-1:0] i_dm_rdata,
    output logic               o_stall,
    output logic               o_mem2reg,
    output logic               o_regWrite,
    output logic [4:0]         o_write_reg,
    output logic [NB_DATA-1:0] o_read_data,
    output logic [NB_DATA-1:0] o_alu_result,
    output logic               o_misaligned
);

    mem_state_e         state_q, state_d;
    logic               dm_req_q, dm_req_d;
    logic               dm_we_q, dm_we_d;
    logic [NB_ADDR-1:0] dm_addr_q, dm_addr_d;
    logic [3:0]         dm_be_q, dm_be_d;
    logic [NB_DATA-1:0] dm_wdata_q, dm_wdata_d;
    logic [1:0]         lat_width_q, lat_width_d;
    logic [1:0]         lat_lo_q, lat_lo_d;
    logic               lat_sign_q, lat_sign_d;
    logic               lat_read_q, lat_read_d;
    logic               lat_mem2reg_q, lat_mem2reg_d;
    logic               lat_regwrite_q, lat_regwrite_d;
    logic [4:0]         lat_write_reg_q, lat_write_reg_d;
    logic [NB_DATA-1:0] lat_result_q, lat_result_d;
    logic               mem2reg_q, mem2reg_d;
    logic               regwrite_q, regwrite_d;
    logic [4:0]         write_reg_q, write_reg_d;
    logic [NB_DATA-1:0] read_data_q, read_data_d;
    logic [NB_DATA-1:0] alu_result_q, alu_result_d;
    logic               misaligned_q, misaligned_d;

    logic               access;
    logic               misalign_hit;
    logic [3:0]         st_be;
    logic [NB_DATA-1:0] st_wdata;
    logic [NB_DATA-1:0] ld_ext;

    assign access = i_memRead | i_memWrite;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_hit = access & is_misaligned(i_width, i_result[1:0]);
`else
    assign misalign_hit = 1'b0;
`endif

    mem_lane_align #(.NB_DATA(NB_DATA)) u_lane_align (
        .i_st_write  (i_memWrite),
        .i_st_width  (i_width),
        .i_st_lo     (i_result[1:0]),
        .i_st_data   (i_data4Mem),
        .i_ld_width  (lat_width_q),
        .i_ld_lo     (lat_lo_q),
        .i_ld_sign   (lat_sign_q),
        .i_ld_rdata  (i_dm_rdata),
        .o_be        (st_be),
        .o_wdata     (st_wdata),
        .o_rdata_ext (ld_ext)
    );

    always_comb begin
        state_d         = state_q;
        dm_req_d        = dm_req_q;
        dm_we_d         = dm_we_q;
        dm_addr_d       = dm_addr_q;
        dm_be_d         = dm_be_q;
        dm_wdata_d      = dm_wdata_q;
        lat_width_d     = lat_width_q;
        lat_lo_d        = lat_lo_q;
        lat_sign_d      = lat_sign_q;
        lat_read_d      = lat_read_q;
        lat_mem2reg_d   = lat_mem2reg_q;
        lat_regwrite_d  = lat_regwrite_q;
        lat_write_reg_d = lat_write_reg_q;
        lat_result_d    = lat_result_q;
        mem2reg_d       = mem2reg_q;
        regwrite_d      = regwrite_q;
        write_reg_d     = write_reg_q;
        read_data_d     = read_data_q;
        alu_result_d    = alu_result_q;
        misaligned_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!i_halt) begin
                    if (misalign_hit) begin
                        mem2reg_d    = 1'b0;
                        regwrite_d   = 1'b0;
                        write_reg_d  = i_write_reg;
                        alu_result_d = i_result;
                        read_data_d  = '0;
                        misaligned_d = 1'b1;
                    end else if (access) begin
                        lat_width_d     = i_width;
                        lat_lo_d        = i_result[1:0];
                        lat_sign_d      = i_sign_flag;
                        lat_read_d      = i_memRead;
                        lat_mem2reg_d   = i_mem2reg;
                        lat_regwrite_d  = i_regWrite;
                        lat_write_reg_d = i_write_reg;
                        lat_result_d    = i_result;
                        dm_req_d        = 1'b1;
                        dm_we_d         = i_memWrite;
                        dm_addr_d       = {i_result[NB_ADDR-1:2], 2'b00};
                        dm_be_d         = st_be;
                        dm_wdata_d      = st_wdata;
                        // MEM/WB carries a bubble while the access is in flight.
                        mem2reg_d       = 1'b0;
                        regwrite_d      = 1'b0;
                        state_d         = ST_BUSY;
                    end else begin
                        mem2reg_d    = i_mem2reg;
                        regwrite_d   = i_regWrite;
                        write_reg_d  = i_write_reg;
                        alu_result_d = i_result;
                        read_data_d  = '0;
                    end
                end
            end
            ST_BUSY: begin
                if (i_dm_ack) begin
                    dm_req_d     = 1'b0;
                    dm_we_d      = 1'b0;
                    mem2reg_d    = lat_mem2reg_q;
                    regwrite_d   = lat_regwrite_q;
                    write_reg_d  = lat_write_reg_q;
                    alu_result_d = lat_result_q;
                    read_data_d  = lat_read_q ? ld_ext : '0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q         <= ST_IDLE;
            dm_req_q        <= 1'b0;
            dm_we_q         <= 1'b0;
            dm_addr_q       <= '0;
            dm_be_q         <= '0;
            dm_wdata_q      <= '0;
            lat_width_q     <= '0;
            lat_lo_q        <= '0;
            lat_sign_q      <= 1'b0;
            lat_read_q      <= 1'b0;
            lat_mem2reg_q   <= 1'b0;
            lat_regwrite_q  <= 1'b0;
            lat_write_reg_q <= '0;
            lat_result_q    <= '0;
            mem2reg_q       <= 1'b0;
            regwrite_q      <= 1'b0;
            write_reg_q     <= '0;
            read_data_q     <= '0;
            alu_result_q    <= '0;
            misaligned_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            dm_req_q        <= dm_req_d;
            dm_we_q         <= dm_we_d;
            dm_addr_q       <= dm_addr_d;
            dm_be_q         <= dm_be_d;
            dm_wdata_q      <= dm_wdata_d;
            lat_width_q     <= lat_width_d;
            lat_lo_q        <= lat_lo_d;
            lat_sign_q      <= lat_sign_d;
            lat_read_q      <= lat_read_d;
            lat_mem2reg_q   <= lat_mem2reg_d;
            lat_regwrite_q  <= lat_regwrite_d;
            lat_write_reg_q <= lat_write_reg_d;
            lat_result_q    <= lat_result_d;
            mem2reg_q       <= mem2reg_d;
            regwrite_q      <= regwrite_d;
            write_reg_q     <= write_reg_d;
            read_data_q     <= read_data_d;
            alu_result_q    <= alu_result_d;
            misaligned_q    <= misaligned_d;
        end
    end

    // Stall is forced low while reset is asserted so upstream is never frozen by a dead stage.
    assign o_stall = i_rst_n &
                     (((state_q == ST_IDLE) & access & !i_halt & !misalign_hit) |
                      ((state_q == ST_BUSY) & !i_dm_ack));

    assign o_dm_req     = dm_req_q;
    assign o_dm_we      = dm_we_q;
    assign o_dm_addr    = dm_addr_q;
    assign o_dm_be      = dm_be_q;
    assign o_dm_wdata   = dm_wdata_q;
    assign o_mem2reg    = mem2reg_q;
    assign o_regWrite   = regwrite_q;
    assign o_write_reg  = write_reg_q;
    assign o_read_data  = read_data_q;
    assign o_alu_result = alu_result_q;
    assign o_misaligned = misaligned_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// tb/tb_memory_access_stage.sv - directed self-checking bench for memory_access_stage
module tb_memory_access_stage;
    import mips_mem_pkg::*;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_halt, i_mem2reg, i_memRead, i_memWrite, i_regWrite;
    logic [1:0]  i_width;
    logic        i_sign_flag;
    logic [4:0]  i_write_reg;
    logic [31:0] i_result, i_data4Mem;
    logic        o_dm_req, o_dm_we;
    logic [31:0] o_dm_addr;
    logic [3:0]  o_dm_be;
    logic [31:0] o_dm_wdata;
    logic        i_dm_ack;
    logic [31:0] i_dm_rdata;
    logic        o_stall, o_mem2reg, o_regWrite;
    logic [4:0]  o_write_reg;
    logic [31:0] o_read_data, o_alu_result;
    logic        o_misaligned;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    memory_access_stage #(.NB_DATA(32), .NB_ADDR(32)) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_halt(i_halt),
        .i_mem2reg(i_mem2reg), .i_memRead(i_memRead), .i_memWrite(i_memWrite),
        .i_regWrite(i_regWrite), .i_width(i_width), .i_sign_flag(i_sign_flag),
        .i_write_reg(i_write_reg), .i_result(i_result), .i_data4Mem(i_data4Mem),
        .o_dm_req(o_dm_req), .o_dm_we(o_dm_we), .o_dm_addr(o_dm_addr),
        .o_dm_be(o_dm_be), .o_dm_wdata(o_dm_wdata), .i_dm_ack(i_dm_ack),
        .i_dm_rdata(i_dm_rdata), .o_stall(o_stall), .o_mem2reg(o_mem2reg),
        .o_regWrite(o_regWrite), .o_write_reg(o_write_reg),
        .o_read_data(o_read_data), .o_alu_result(o_alu_result),
        .o_misaligned(o_misaligned)
    );

    task automatic clear_inputs();
        i_halt = 0; i_mem2reg = 0; i_memRead = 0; i_memWrite = 0; i_regWrite = 0;
        i_width = W_BYTE; i_sign_flag = 0; i_write_reg = 0; i_result = 0;
        i_data4Mem = 0; i_dm_ack = 0; i_dm_rdata = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_access(input logic rd, input logic wr, input logic [1:0] w,
                                input logic s, input logic [31:0] addr,
                                input logic [31:0] data, input logic [4:0] wreg);
        i_memRead = rd; i_memWrite = wr; i_mem2reg = rd; i_regWrite = rd;
        i_width = w; i_sign_flag = s; i_result = addr; i_data4Mem = data;
        i_write_reg = wreg;
        #1;
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [1:0] w,
                           input logic s, input logic [31:0] rdata);
        drive_access(1, 0, w, s, addr, 32'h0, 5'd9);
        tick();
        i_dm_ack = 1; i_dm_rdata = rdata;
        tick();
    endtask

    task automatic test_reset();
        i_rst_n = 0;
        clear_inputs();
        #3;
        total++; if (o_dm_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0h exp=0", o_dm_req); end
        total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0h exp=0", o_stall); end
        total++; if (o_dm_be !== 4'h0) begin bad++; $display("FAIL reset_be got=%0h exp=0", o_dm_be); end
        total++; if (o_regWrite !== 1'b0 || o_alu_result !== 32'h0 || o_read_data !== 32'h0)
            begin bad++; $display("FAIL reset_memwb got=%0h/%0h/%0h exp=0/0/0", o_regWrite, o_alu_result, o_read_data); end
        total++; if (o_misaligned !== 1'b0) begin bad++; $display("FAIL reset_misaligned got=%0h exp=0", o_misaligned); end
        @(negedge clk);
        i_rst_n = 1;
        tick();
    endtask

    task automatic test_alu_passthrough();
        clear_inputs();
        i_regWrite = 1; i_result = 32'h1234; i_write_reg = 5'd5;
        #1;
        total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL alu_stall got=%0h exp=0", o_stall); end
        tick();
        total++; if (o_alu_result !== 32'h1234) begin bad++; $display("FAIL alu_result got=%0h exp=1234", o_alu_result); end
        total++; if (o_regWrite !== 1'b1 || o_write_reg !== 5'd5)
            begin bad++; $display("FAIL alu_regwrite got=%0h/%0d exp=1/5", o_regWrite, o_write_reg); end
        total++; if (o_dm_req !== 1'b0 || o_stall !== 1'b0)
            begin bad++; $display("FAIL alu_no_req got=%0h/%0h exp=0/0", o_dm_req, o_stall); end
    endtask

    task automatic test_store_word();
        int req_cycles = 0;
        clear_inputs();
        drive_access(0, 1, W_WORD, 0, 32'h10, 32'hDEADBEEF, 5'd0);
        total++; if (o_stall !== 1'b1) begin bad++; $display("FAIL sw_accept_stall got=%0h exp=1", o_stall); end
        tick();
        total++; if (o_dm_addr !== 32'h10 || o_dm_be !== 4'b1111 || o_dm_we !== 1'b1 || o_dm_wdata !== 32'hDEADBEEF)
            begin bad++; $display("FAIL sw_fields got=%0h/%0h/%0h/%0h exp=10/f/1/deadbeef", o_dm_addr, o_dm_be, o_dm_we, o_dm_wdata); end
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin i_dm_ack = 1; #1; end
            if (o_dm_req === 1'b1) req_cycles++;
            total++; if (o_stall !== (i < 2))
                begin bad++; $display("FAIL sw_stall_c%0d got=%0h exp=%0h", i, o_stall, (i < 2)); end
            tick();
        end
        total++; if (req_cycles != 3) begin bad++; $display("FAIL sw_req_cycles got=%0d exp=3", req_cycles); end
        total++; if (o_dm_req !== 1'b0 || o_regWrite !== 1'b0)
            begin bad++; $display("FAIL sw_done got=%0h/%0h exp=0/0", o_dm_req, o_regWrite); end
        clear_inputs();
    endtask

    task automatic test_store_sub();
        clear_inputs();
        drive_access(0, 1, W_BYTE, 0, 32'h13, 32'h000000A5, 5'd0);
        tick();
        total++; if (o_dm_be !== 4'b1000 || o_dm_wdata !== 32'hA5A5A5A5 || o_dm_addr !== 32'h10)
            begin bad++; $display("FAIL sb_fields got=%0h/%0h/%0h exp=8/a5a5a5a5/10", o_dm_be, o_dm_wdata, o_dm_addr); end
        i_dm_ack = 1;
        tick();
        clear_inputs();
        drive_access(0, 1, W_HALF, 0, 32'h16, 32'h1234CAFE, 5'd0);
        tick();
        total++; if (o_dm_be !== 4'b1100 || o_dm_wdata !== 32'hCAFECAFE || o_dm_addr !== 32'h14)
            begin bad++; $display("FAIL sh_fields got=%0h/%0h/%0h exp=c/cafecafe/14", o_dm_be, o_dm_wdata, o_dm_addr); end
        i_dm_ack = 1;
        tick();
        clear_inputs();
    endtask

    task automatic test_loads();
        clear_inputs();
        drive_access(1, 0, W_BYTE, 1, 32'h12, 32'h0, 5'd9);
        tick();
        total++; if (o_dm_req !== 1'b1 || o_dm_we !== 1'b0 || o_dm_be !== 4'b1111 || o_dm_addr !== 32'h10)
            begin bad++; $display("FAIL lb_req got=%0h/%0h/%0h/%0h exp=1/0/f/10", o_dm_req, o_dm_we, o_dm_be, o_dm_addr); end
        total++; if (o_regWrite !== 1'b0) begin bad++; $display("FAIL lb_bubble got=%0h exp=0", o_regWrite); end
        i_dm_ack = 1; i_dm_rdata = 32'h0080_0000;
        tick();
        total++; if (o_read_data !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_signed got=%0h exp=ffffff80", o_read_data); end
        total++; if (o_regWrite !== 1'b1 || o_mem2reg !== 1'b1 || o_write_reg !== 5'd9 || o_alu_result !== 32'h12 || o_dm_req !== 1'b0)
            begin bad++; $display("FAIL lb_memwb got=%0h/%0h/%0d/%0h/%0h exp=1/1/9/12/0", o_regWrite, o_mem2reg, o_write_reg, o_alu_result, o_dm_req); end
        clear_inputs();
        do_load(32'h12, W_BYTE, 0, 32'h0080_0000);
        total++; if (o_read_data !== 32'h00000080) begin bad++; $display("FAIL lbu got=%0h exp=80", o_read_data); end
        clear_inputs();
        do_load(32'h2, W_HALF, 0, 32'hBEEF0000);
        total++; if (o_read_data !== 32'h0000BEEF) begin bad++; $display("FAIL lhu got=%0h exp=beef", o_read_data); end
        clear_inputs();
        do_load(32'h0, W_HALF, 1, 32'h12348001);
        total++; if (o_read_data !== 32'hFFFF8001) begin bad++; $display("FAIL lh got=%0h exp=ffff8001", o_read_data); end
        clear_inputs();
        do_load(32'h8, W_WORD, 1, 32'hCAFEF00D);
        total++; if (o_read_data !== 32'hCAFEF00D) begin bad++; $display("FAIL lw got=%0h exp=cafef00d", o_read_data); end
        clear_inputs();
    endtask

    task automatic test_halt_and_idle_ack();
        clear_inputs();
        i_halt = 1;
        drive_access(1, 0, W_WORD, 0, 32'h20, 32'h0, 5'd4);
        total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL halt_stall got=%0h exp=0", o_stall); end
        tick();
        tick();
        total++; if (o_dm_req !== 1'b0 || o_alu_result !== 32'h8 || o_read_data !== 32'hCAFEF00D)
            begin bad++; $display("FAIL halt_hold got=%0h/%0h/%0h exp=0/8/cafef00d", o_dm_req, o_alu_result, o_read_data); end
        clear_inputs();
        i_dm_ack = 1; i_result = 32'h55;
        tick();
        total++; if (o_dm_req !== 1'b0 || o_alu_result !== 32'h55 || o_read_data !== 32'h0)
            begin bad++; $display("FAIL idle_ack got=%0h/%0h/%0h exp=0/55/0", o_dm_req, o_alu_result, o_read_data); end
        clear_inputs();
    endtask

    task automatic test_reset_busy();
        clear_inputs();
        drive_access(1, 0, W_WORD, 0, 32'h40, 32'h0, 5'd2);
        tick();
        total++; if (o_dm_req !== 1'b1) begin bad++; $display("FAIL rstb_req_before got=%0h exp=1", o_dm_req); end
        i_rst_n = 0;
        #1;
        total++; if (o_dm_req !== 1'b0 || o_stall !== 1'b0 || o_dm_addr !== 32'h0)
            begin bad++; $display("FAIL rstb_drop got=%0h/%0h/%0h exp=0/0/0", o_dm_req, o_stall, o_dm_addr); end
        total++; if (o_regWrite !== 1'b0 || o_alu_result !== 32'h0)
            begin bad++; $display("FAIL rstb_memwb got=%0h/%0h exp=0/0", o_regWrite, o_alu_result); end
        clear_inputs();
        i_dm_ack = 1;
        @(negedge clk);
        i_rst_n = 1;
        tick();
        total++; if (o_dm_req !== 1'b0 || o_regWrite !== 1'b0 || o_read_data !== 32'h0)
            begin bad++; $display("FAIL rstb_no_completion got=%0h/%0h/%0h exp=0/0/0", o_dm_req, o_regWrite, o_read_data); end
        clear_inputs();
    endtask

    task automatic test_misaligned();
        clear_inputs();
        drive_access(1, 0, W_WORD, 0, 32'h6, 32'h0, 5'd3);
`ifdef MEM_ALIGN_CHECK_EN
        total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL mis_stall got=%0h exp=0", o_stall); end
        tick();
        total++; if (o_dm_req !== 1'b0 || o_misaligned !== 1'b1 || o_regWrite !== 1'b0)
            begin bad++; $display("FAIL mis_pulse got=%0h/%0h/%0h exp=0/1/0", o_dm_req, o_misaligned, o_regWrite); end
        clear_inputs();
        tick();
        total++; if (o_misaligned !== 1'b0) begin bad++; $display("FAIL mis_one_cycle got=%0h exp=0", o_misaligned); end
`else
        tick();
        total++; if (o_dm_req !== 1'b1 || o_dm_addr !== 32'h4 || o_misaligned !== 1'b0)
            begin bad++; $display("FAIL unaligned_req got=%0h/%0h/%0h exp=1/4/0", o_dm_req, o_dm_addr, o_misaligned); end
        i_dm_ack = 1; i_dm_rdata = 32'h01020304;
        tick();
        total++; if (o_regWrite !== 1'b1 || o_read_data !== 32'h01020304 || o_misaligned !== 1'b0)
            begin bad++; $display("FAIL unaligned_done got=%0h/%0h/%0h exp=1/01020304/0", o_regWrite, o_read_data, o_misaligned); end
        clear_inputs();
`endif
    endtask

    initial begin
        test_reset();
        test_alu_passthrough();
        test_store_word();
        test_store_sub();
        test_loads();
        test_halt_and_idle_ack();
        test_reset_busy();
        test_misaligned();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
